// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a valid/ready output register.
// Define UART_RX_PARITY_EN to add a parity bit after the data and enable parity_err.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in,
   input  logic                 parity_odd,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] LAST      = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, COMMIT} state_t;
`else
   typedef enum logic [2:0] {IDLE, DATA, STOP, COMMIT} state_t;
`endif

   state_t               state, state_d;
   logic [1:0]           sync_pipe;
   logic                 in_s;
   logic [CW-1:0]        sample_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_q;
   logic                 stop_bad;
   logic                 sample_pt;
   logic                 cnt_clr, bit_clr, bit_inc, shift_en, stop_chk, commit, frame_start;
   logic                 xfer, load;

   // Sync flops idle high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_pipe <= 2'b11;
      else        sync_pipe <= {sync_pipe[0], in};
   end
   assign in_s = sync_pipe[1];

   assign sample_pt = (sample_cnt == LAST);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

`ifdef UART_RX_PARITY_EN
   logic par_chk;
`endif

   always_comb begin
      state_d     = state;
      cnt_clr     = 1'b0;
      bit_clr     = 1'b0;
      bit_inc     = 1'b0;
      shift_en    = 1'b0;
      stop_chk    = 1'b0;
      commit      = 1'b0;
      frame_start = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_chk     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (in_s) begin
               cnt_clr = 1'b1;
            end else if (sample_cnt == HALF_M1) begin
               frame_start = 1'b1;
               cnt_clr     = 1'b1;
               bit_clr     = 1'b1;
               state_d     = DATA;
            end
         end
         DATA: begin
            if (sample_pt) begin
               shift_en = 1'b1;
               if (bit_cnt == DATA_LAST) begin
                  bit_clr = 1'b1;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (sample_pt) begin
               par_chk = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (sample_pt) begin
               stop_chk = 1'b1;
               if (bit_cnt == STOP_LAST) begin
                  bit_clr = 1'b1;
                  state_d = COMMIT;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Disable wins over everything: drop the frame, keep the output register
      if (!en) begin
         state_d     = IDLE;
         cnt_clr     = 1'b1;
         bit_clr     = 1'b1;
         bit_inc     = 1'b0;
         shift_en    = 1'b0;
         stop_chk    = 1'b0;
         commit      = 1'b0;
         frame_start = 1'b0;
`ifdef UART_RX_PARITY_EN
         par_chk     = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift_q    <= '0;
         stop_bad   <= 1'b0;
      end else begin
         if (cnt_clr) sample_cnt <= '0;
         else         sample_cnt <= sample_cnt + 1'b1;
         if (bit_clr)      bit_cnt <= '0;
         else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
         // LSB arrives first, so shifting in at the MSB leaves the word aligned
         if (shift_en) shift_q <= {in_s, shift_q[DATA_BITS-1:1]};
         if (frame_start)          stop_bad <= 1'b0;
         else if (stop_chk && !in_s) stop_bad <= 1'b1;
      end
   end

   assign xfer = out_valid && out_ready;
   // A word taken on the commit cycle frees the register for the new one
   assign load = commit && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) out <= shift_q;
         if (load)      out_valid <= 1'b1;
         else if (xfer) out_valid <= 1'b0;
         if (load)      frame_err <= stop_bad;
         else if (xfer) frame_err <= 1'b0;
         if (xfer)                      overrun <= 1'b0;
         else if (commit && out_valid)  overrun <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad, parity_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bad      <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if (frame_start)  par_bad <= 1'b0;
         else if (par_chk) par_bad <= (^shift_q) ^ in_s ^ parity_odd;
         if (load) parity_err_q <= par_bad;
      end
   end
   assign parity_err = parity_err_q;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
   assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default instance (8/16/1) and a 5-bit/8x/2-stop instance.
module tb_uart_rx_param;
   localparam int T = 10;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // negedges from driving the start bit until out_valid is first seen high
   localparam int LAT_A = 3 + 16/2 + 16*(8 + PB + 1);
   localparam int LAT_B = 3 + 8/2 + 8*(5 + PB + 2);

   typedef struct packed {
      logic [8:0] data;
      logic       fe;
      logic       ov;
      logic       pe;
   } exp_t;

   typedef struct packed {
      logic [8:0] data;
      logic       stop_v;
      logic [8:0] exp_out;
      logic       exp_fe;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic en_a = 1'b1, en_b = 1'b1, in_a = 1'b1, in_b = 1'b1, parity_odd = 1'b0;
   logic ready_a = 1'b1, ready_b = 1'b1;
   logic busy_a, valid_a, fe_a, ov_a, pe_a;
   logic busy_b, valid_b, fe_b, ov_b, pe_b;
   logic [7:0] out_a;
   logic [4:0] out_b;

   int   n_chk = 0, n_fail = 0;
   exp_t q_a[$], q_b[$];
   time  start_a = 0, start_b = 0, rise_a = 0, rise_b = 0;
   logic pv_a = 1'b0, pv_b = 1'b0;
   vec_t vecs[6];

   always #(T/2) clk = ~clk;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .in(in_a), .parity_odd(parity_odd),
      .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a), .out(out_a),
      .frame_err(fe_a), .overrun(ov_a), .parity_err(pe_a));

   uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .in(in_b), .parity_odd(parity_odd),
      .busy(busy_b), .out_valid(valid_b), .out_ready(ready_b), .out(out_b),
      .frame_err(fe_b), .overrun(ov_b), .parity_err(pe_b));

   task automatic chk1(input string name, input logic act, input logic exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp_v);
      end
   endtask

   task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) in_b = v;
      else     in_a = v;
   endtask

   task automatic drive_frame(input bit sel, input logic [8:0] d, input logic stop_v, input logic par_v);
      int os, nb, ns;
      os = sel ? 8 : 16;
      nb = sel ? 5 : 8;
      ns = sel ? 2 : 1;
      @(negedge clk);
      if (sel) start_b = $time;
      else     start_a = $time;
      set_line(sel, 1'b0);
      repeat (os) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         set_line(sel, d[i]);
         repeat (os) @(negedge clk);
      end
      if (PB == 1) begin
         set_line(sel, par_v);
         repeat (os) @(negedge clk);
      end
      for (int i = 0; i < ns; i++) begin
         set_line(sel, stop_v);
         repeat (os) @(negedge clk);
      end
      set_line(sel, 1'b1);
      repeat (os) @(negedge clk);
   endtask

   task automatic drain(input bit sel);
      for (int i = 0; i < 300; i++) begin
         if ((sel ? q_b.size() : q_a.size()) == 0) break;
         @(negedge clk);
      end
      chkw(sel ? "drain_b" : "drain_a", 32'(sel ? q_b.size() : q_a.size()), 32'd0);
   endtask

   task automatic set_ready(input bit sel, input logic v);
      @(posedge clk);
      #1;
      if (sel) ready_b = v;
      else     ready_a = v;
   endtask

   // Scoreboard: every word the consumer takes must match the oldest expectation
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (valid_a && !pv_a) rise_a <= $time;
      pv_a <= valid_a;
      if (valid_a && ready_a) begin
         if (q_a.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_a: unexpected word got %0h required none", out_a);
         end else begin
            e = q_a.pop_front();
            chkw("sb_a_out", 32'(out_a), 32'(e.data));
            chk1("sb_a_fe", fe_a, e.fe);
            chk1("sb_a_ov", ov_a, e.ov);
            chk1("sb_a_pe", pe_a, e.pe);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (valid_b && !pv_b) rise_b <= $time;
      pv_b <= valid_b;
      if (valid_b && ready_b) begin
         if (q_b.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_b: unexpected word got %0h required none", out_b);
         end else begin
            e = q_b.pop_front();
            chkw("sb_b_out", 32'(out_b), 32'(e.data));
            chk1("sb_b_fe", fe_b, e.fe);
            chk1("sb_b_ov", ov_b, e.ov);
            chk1("sb_b_pe", pe_b, e.pe);
         end
      end
   end

   initial begin : watchdog
      #(60000 * T);
      $display("FAIL watchdog: run did not finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      bit saw;
      vecs[0] = '{9'h0A5, 1'b1, 9'h0A5, 1'b0};
      vecs[1] = '{9'h000, 1'b1, 9'h000, 1'b0};
      vecs[2] = '{9'h0FF, 1'b1, 9'h0FF, 1'b0};
      vecs[3] = '{9'h055, 1'b0, 9'h055, 1'b1};
      vecs[4] = '{9'h080, 1'b1, 9'h080, 1'b0};
      vecs[5] = '{9'h001, 1'b1, 9'h001, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      chk1("rst_busy_a", busy_a, 1'b0);
      chk1("rst_valid_a", valid_a, 1'b0);
      chkw("rst_out_a", 32'(out_a), 32'd0);
      chk1("rst_fe_a", fe_a, 1'b0);
      chk1("rst_ov_a", ov_a, 1'b0);
      chk1("rst_pe_a", pe_a, 1'b0);
      chk1("rst_valid_b", valid_b, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // table-driven frames, consumer always ready
      for (int k = 0; k < 6; k++) begin
         rise_a = 0;
         q_a.push_back('{data: vecs[k].exp_out, fe: vecs[k].exp_fe, ov: 1'b0, pe: 1'b0});
         drive_frame(1'b0, vecs[k].data, vecs[k].stop_v, (^vecs[k].data) ^ parity_odd);
         drain(1'b0);
         chkw("lat_a", 32'(rise_a - start_a), 32'(LAT_A * T));
         chk1("fe_cleared_a", fe_a, 1'b0);
         chk1("valid_idle_a", valid_a, 1'b0);
      end

      // short low glitch in IDLE
      saw = 1'b0;
      @(negedge clk);
      in_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 5) in_a = 1'b1;
         saw = saw | busy_a;
      end
      chk1("glitch_busy", saw, 1'b0);
      chk1("glitch_valid", valid_a, 1'b0);
      chk1("glitch_fe", fe_a, 1'b0);
      chk1("glitch_ov", ov_a, 1'b0);

      // overrun: two frames while the consumer stalls
      set_ready(1'b0, 1'b0);
      q_a.push_back('{data: 9'h03C, fe: 1'b0, ov: 1'b1, pe: 1'b0});
      drive_frame(1'b0, 9'h03C, 1'b1, (^9'h03C) ^ parity_odd);
      drive_frame(1'b0, 9'h0C3, 1'b1, (^9'h0C3) ^ parity_odd);
      chkw("ovr_out", 32'(out_a), 32'h3C);
      chk1("ovr_valid", valid_a, 1'b1);
      chk1("ovr_flag", ov_a, 1'b1);
      set_ready(1'b0, 1'b1);
      set_ready(1'b0, 1'b0);
      @(negedge clk);
      chk1("ovr_valid_clr", valid_a, 1'b0);
      chk1("ovr_flag_clr", ov_a, 1'b0);
      chkw("ovr_out_hold", 32'(out_a), 32'h3C);
      drain(1'b0);
      set_ready(1'b0, 1'b1);

      // en dropped mid-frame discards it
      fork
         drive_frame(1'b0, 9'h0F0, 1'b1, (^9'h0F0) ^ parity_odd);
         begin
            repeat (40) @(negedge clk);
            chk1("en_busy_before", busy_a, 1'b1);
            en_a = 1'b0;
            @(negedge clk);
            chk1("en_busy_after", busy_a, 1'b0);
         end
      join
      en_a = 1'b1;
      repeat (20) @(negedge clk);
      chk1("en_no_word", valid_a, 1'b0);

`ifdef UART_RX_PARITY_EN
      q_a.push_back('{data: 9'h007, fe: 1'b0, ov: 1'b0, pe: 1'b0});
      drive_frame(1'b0, 9'h007, 1'b1, 1'b1);
      drain(1'b0);
      q_a.push_back('{data: 9'h007, fe: 1'b0, ov: 1'b0, pe: 1'b1});
      drive_frame(1'b0, 9'h007, 1'b1, 1'b0);
      drain(1'b0);
      chk1("par_err_held", pe_a, 1'b1);
`endif

      // narrow instance: 5 data bits, 8x, 2 stop bits
      set_ready(1'b1, 1'b0);
      rise_b = 0;
      drive_frame(1'b1, 9'h015, 1'b1, (^9'h015) ^ parity_odd);
      chkw("b_out", 32'(out_b), 32'h15);
      chk1("b_valid", valid_b, 1'b1);
      chk1("b_fe", fe_b, 1'b0);
      chkw("lat_b", 32'(rise_b - start_b), 32'(LAT_B * T));

      // asynchronous reset during data bits
      fork
         drive_frame(1'b1, 9'h01E, 1'b1, 1'b1);
         begin
            repeat (28) @(negedge clk);
            chk1("b_busy_mid", busy_b, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            chk1("b_rst_busy", busy_b, 1'b0);
            chk1("b_rst_valid", valid_b, 1'b0);
            chkw("b_rst_out", 32'(out_b), 32'd0);
            chkw("a_rst_out", 32'(out_a), 32'd0);
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
      join
      repeat (10) @(negedge clk);
      chk1("b_no_partial", valid_b, 1'b0);
      set_ready(1'b1, 1'b1);
      rise_b = 0;
      q_b.push_back('{data: 9'h00A, fe: 1'b0, ov: 1'b0, pe: 1'b0});
      drive_frame(1'b1, 9'h00A, 1'b1, (^9'h00A) ^ parity_odd);
      drain(1'b1);
      chkw("lat_b2", 32'(rise_b - start_b), 32'(LAT_B * T));

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
